// File: rtl/floating_divider_32b_if.sv
// Request/result bundle for the single-precision divider: operands and start
// travel toward the divider, quotient, flags and status travel back.
interface floating_divider_32b_if;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic        ov;
    logic        dz;
    logic        busy;
    logic        done;

    modport master (
        output start, a, b,
        input  c, ov, dz, busy, done
    );

    modport slave (
        input  start, a, b,
        output c, ov, dz, busy, done
    );
endinterface

// File: rtl/floating_divider_32b.sv
// Iterative IEEE-754 single-precision divider, one quotient bit per clock.
// Denormals flush to zero and the quotient is truncated (round toward zero).
// Fixed 28-cycle latency from the accepting edge to the done pulse.
module floating_divider_32b (
    input  logic                  clk,
    input  logic                  rst,
    floating_divider_32b_if.slave bus
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PREP = 3'd1;
    localparam logic [2:0] S_DIV  = 3'd2;
    localparam logic [2:0] S_NORM = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic [2:0]        state;
    logic [31:0]       a_reg;
    logic [31:0]       b_reg;
    logic              sign;
    logic signed [9:0] exp_val;
    logic [23:0]       div_mant;
    logic [24:0]       rem;
    logic [24:0]       quo;
    logic [4:0]        count;
    logic              special;
    logic [31:0]       special_c;
    logic              special_dz;
    logic [31:0]       c_reg;
    logic              ov_reg;
    logic              dz_reg;
    logic              busy_reg;
    logic              done_reg;

    // Operand unpacking (from the captured operands)
    logic [7:0]        ea, eb;
    logic [22:0]       fa, fb;
    logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic              prep_sign;
    logic signed [9:0] prep_exp;
    logic              prep_special;
    logic [31:0]       prep_c;
    logic              prep_dz;

    assign ea        = a_reg[30:23];
    assign eb        = b_reg[30:23];
    assign fa        = a_reg[22:0];
    assign fb        = b_reg[22:0];
    assign a_zero    = (ea == 8'h00);
    assign b_zero    = (eb == 8'h00);
    assign a_inf     = (ea == 8'hFF) && (fa == 23'd0);
    assign b_inf     = (eb == 8'hFF) && (fb == 23'd0);
    assign a_nan     = (ea == 8'hFF) && (fa != 23'd0);
    assign b_nan     = (eb == 8'hFF) && (fb != 23'd0);
    assign prep_sign = a_reg[31] ^ b_reg[31];
    assign prep_exp  = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;

    // Special-case classification, highest priority first
    always_comb begin
        prep_special = 1'b1;
        prep_c       = QNAN;
        prep_dz      = 1'b0;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            prep_c = QNAN;
        end else if (a_inf) begin
            prep_c = {prep_sign, 8'hFF, 23'd0};
        end else if (b_zero) begin
            prep_c  = {prep_sign, 8'hFF, 23'd0};
            prep_dz = 1'b1;
        end else if (a_zero || b_inf) begin
            prep_c = {prep_sign, 31'd0};
        end else begin
            prep_special = 1'b0;
        end
    end

    // One restoring-division step: keep the difference when it does not go
    // negative, then shift the partial remainder for the next quotient bit.
    // The remainder stays below twice the divisor, so 25 bits are enough.
    logic        step_ge;
    logic [24:0] step_diff;
    logic [24:0] step_sel;
    logic [24:0] rem_next;

    always_comb begin
        step_ge   = (rem >= {1'b0, div_mant});
        step_diff = rem - {1'b0, div_mant};
        step_sel  = step_ge ? step_diff : rem;
        rem_next  = step_sel << 1;
    end

    // Normalisation, range check and special-result override
    logic [22:0]       norm_frac;
    logic signed [9:0] norm_exp;
    logic [31:0]       norm_c;
    logic              norm_ov;
    logic              norm_dz;

    always_comb begin
        if (quo[24]) begin
            norm_frac = quo[23:1];
            norm_exp  = exp_val;
        end else begin
            norm_frac = quo[22:0];
            norm_exp  = exp_val - 10'sd1;
        end
        norm_ov = 1'b0;
        norm_dz = 1'b0;
        if (special) begin
            norm_c  = special_c;
            norm_dz = special_dz;
        end else if (norm_exp >= 10'sd255) begin
            norm_c  = {sign, 8'hFF, 23'd0};
            norm_ov = 1'b1;
        end else if (norm_exp <= 10'sd0) begin
            norm_c  = {sign, 31'd0};
        end else begin
            norm_c  = {sign, norm_exp[7:0], norm_frac};
        end
    end

    // Sequencer and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            sign       <= 1'b0;
            exp_val    <= '0;
            div_mant   <= '0;
            rem        <= '0;
            quo        <= '0;
            count      <= '0;
            special    <= 1'b0;
            special_c  <= '0;
            special_dz <= 1'b0;
            c_reg      <= '0;
            ov_reg     <= 1'b0;
            dz_reg     <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done_reg <= 1'b0;
                    if (bus.start) begin
                        a_reg    <= bus.a;
                        b_reg    <= bus.b;
                        ov_reg   <= 1'b0;
                        dz_reg   <= 1'b0;
                        busy_reg <= 1'b1;
                        state    <= S_PREP;
                    end
                end
                S_PREP: begin
                    sign       <= prep_sign;
                    exp_val    <= prep_exp;
                    rem        <= {1'b0, 1'b1, fa};
                    div_mant   <= {1'b1, fb};
                    quo        <= '0;
                    count      <= '0;
                    special    <= prep_special;
                    special_c  <= prep_c;
                    special_dz <= prep_dz;
                    state      <= S_DIV;
                end
                S_DIV: begin
                    rem   <= rem_next;
                    quo   <= {quo[23:0], step_ge};
                    count <= count + 5'd1;
                    if (count == 5'd24) begin
                        state <= S_NORM;
                    end
                end
                S_NORM: begin
                    c_reg  <= norm_c;
                    ov_reg <= norm_ov;
                    dz_reg <= norm_dz;
                    state  <= S_DONE;
                end
                S_DONE: begin
                    done_reg <= 1'b1;
                    busy_reg <= 1'b0;
                    state    <= S_IDLE;
                end
                default: begin
                    state    <= S_IDLE;
                    busy_reg <= 1'b0;
                    done_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.c    = c_reg;
    assign bus.ov   = ov_reg;
    assign bus.dz   = dz_reg;
    assign bus.busy = busy_reg;
    assign bus.done = done_reg;
endmodule

// File: tb/tb_floating_divider_32b.sv
// Self-checking bench for floating_divider_32b: directed cases from the
// arithmetic rules plus random operands checked against an integer model.
module tb_floating_divider_32b;
    logic clk;
    logic rst;
    int   compared;
    int   mismatched;

    floating_divider_32b_if bus ();

    floating_divider_32b dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {ov, dz, c} from the IEEE rules with plain integer division
    function automatic logic [33:0] ref_div(input logic [31:0] x, input logic [31:0] y);
        logic        s;
        int          ex, ey, e;
        bit          xz, yz, xi, yi, xn, yn;
        logic [31:0] inf_v, zero_v;
        longint unsigned num, den, q;
        logic [22:0] frac;
        logic [7:0]  e8;
        s      = x[31] ^ y[31];
        ex     = int'(x[30:23]);
        ey     = int'(y[30:23]);
        xz     = (ex == 0);
        yz     = (ey == 0);
        xi     = (ex == 255) && (x[22:0] == 0);
        yi     = (ey == 255) && (y[22:0] == 0);
        xn     = (ex == 255) && (x[22:0] != 0);
        yn     = (ey == 255) && (y[22:0] != 0);
        inf_v  = {s, 8'hFF, 23'd0};
        zero_v = {s, 31'd0};
        if (xn || yn || (xz && yz) || (xi && yi)) return {2'b00, 32'h7FC00000};
        if (xi) return {2'b00, inf_v};
        if (yz) return {2'b01, inf_v};
        if (xz || yi) return {2'b00, zero_v};
        num = (longint'(8388608) + longint'(x[22:0])) * 64'd16777216;
        den = longint'(8388608) + longint'(y[22:0]);
        q   = num / den;
        e   = ex - ey + 127;
        if (q >= 64'd16777216) begin
            frac = 23'((q >> 1) & 64'h7FFFFF);
        end else begin
            frac = 23'(q & 64'h7FFFFF);
            e    = e - 1;
        end
        if (e >= 255) return {2'b10, inf_v};
        if (e <= 0) return {2'b00, zero_v};
        e8 = 8'(e);
        return {2'b00, s, e8, frac};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        compared++;
        assert (obs === exp_v) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // One operation: optional pre-launched start, optional ignored pokes at
    // cycles 5 and 27, optional chained launch during the done cycle.
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input bit pre_started,
                          input bit poke, input bit chain, input logic [31:0] na,
                          input logic [31:0] nb, input string tag);
        logic [33:0] exp_r;
        int cycles;
        exp_r = ref_div(ta, tb_v);
        if (!pre_started) begin
            @(negedge clk);
            bus.a = ta;
            bus.b = tb_v;
            bus.start = 1'b1;
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a = $urandom;
        bus.b = $urandom;
        chk({tag, "_busy_on"}, {31'd0, bus.busy}, 32'd1);
        cycles = 0;
        while (cycles < 40) begin
            @(posedge clk);
            #1;
            cycles++;
            if (bus.done && bus.busy) chk({tag, "_done_busy"}, 32'd1, 32'd0);
            if (bus.done) break;
            if (poke && (cycles == 5 || cycles == 27)) begin
                bus.start = 1'b1;
                bus.a = $urandom;
                bus.b = $urandom;
            end else begin
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        chk({tag, "_latency"}, 32'(cycles), 32'd28);
        chk({tag, "_c"}, bus.c, exp_r[31:0]);
        chk({tag, "_ov"}, {31'd0, bus.ov}, {31'd0, exp_r[33]});
        chk({tag, "_dz"}, {31'd0, bus.dz}, {31'd0, exp_r[32]});
        chk({tag, "_busy_off"}, {31'd0, bus.busy}, 32'd0);
        $display("op %s: a=%h b=%h c=%h ov=%0d dz=%0d expected c=%h ov=%0d dz=%0d",
                 tag, ta, tb_v, bus.c, bus.ov, bus.dz, exp_r[31:0], exp_r[33], exp_r[32]);
        if (chain) begin
            bus.a = na;
            bus.b = nb;
            bus.start = 1'b1;
        end else begin
            @(posedge clk);
            #1;
            chk({tag, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
            chk({tag, "_idle_after"}, {31'd0, bus.busy}, 32'd0);
        end
    endtask

    initial begin
        int done_seen;
        logic [31:0] ra, rb;
        compared   = 0;
        mismatched = 0;
        bus.start  = 1'b0;
        bus.a      = '0;
        bus.b      = '0;
        rst        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_c", bus.c, 32'd0);
        chk("reset_ov", {31'd0, bus.ov}, 32'd0);
        chk("reset_dz", {31'd0, bus.dz}, 32'd0);
        chk("reset_busy", {31'd0, bus.busy}, 32'd0);
        chk("reset_done", {31'd0, bus.done}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Directed: values fixed by hand against the arithmetic rules
        run_op(32'h40C00000, 32'h40000000, 0, 0, 0, 0, 0, "six_by_two");
        chk("six_by_two_abs", bus.c, 32'h40400000);
        run_op(32'hC0C00000, 32'h40000000, 0, 0, 0, 0, 0, "neg_six_by_two");
        chk("neg_six_by_two_abs", bus.c, 32'hC0400000);
        run_op(32'h3F800000, 32'h40400000, 0, 0, 0, 0, 0, "one_third");
        chk("one_third_abs", bus.c, 32'h3EAAAAAA);
        run_op(32'h3F800000, 32'h00000000, 0, 0, 0, 0, 0, "div_zero");
        chk("div_zero_abs", {bus.c[31:1], bus.dz}, {31'h3FC00000, 1'b1});
        run_op(32'h00000000, 32'h00000000, 0, 0, 0, 0, 0, "zero_by_zero");
        chk("zero_by_zero_abs", bus.c, 32'h7FC00000);
        run_op(32'h7F800000, 32'h7F800000, 0, 0, 0, 0, 0, "inf_by_inf");
        chk("inf_by_inf_abs", bus.c, 32'h7FC00000);
        run_op(32'h7F000000, 32'h3E800000, 0, 0, 0, 0, 0, "overflow");
        chk("overflow_abs", {bus.c[31:1], bus.ov}, {31'h3FC00000, 1'b1});
        run_op(32'h00800000, 32'h40000000, 0, 0, 0, 0, 0, "underflow");
        chk("underflow_abs", {bus.c[31:1], bus.ov}, 32'd0);
        run_op(32'hFF800000, 32'h40000000, 0, 0, 0, 0, 0, "neg_inf_num");
        run_op(32'h40000000, 32'hFF800000, 0, 0, 0, 0, 0, "by_neg_inf");
        run_op(32'h7FC12345, 32'h3F800000, 0, 0, 0, 0, 0, "nan_in");
        run_op(32'h00012345, 32'h3F800000, 0, 0, 0, 0, 0, "denorm_flush");

        // Handshake: pokes while busy ignored, back-to-back via done cycle
        run_op(32'h40C00000, 32'h40000000, 0, 1, 0, 0, 0, "poke");
        chk("poke_abs", bus.c, 32'h40400000);
        run_op(32'h40C00000, 32'h40000000, 0, 0, 1, 32'h3F800000, 32'h40400000, "chain_first");
        run_op(32'h3F800000, 32'h40400000, 1, 0, 0, 0, 0, "chain_second");
        chk("chain_second_abs", bus.c, 32'h3EAAAAAA);

        // Reset in the middle of a 6/2 divide
        @(negedge clk);
        bus.a = 32'h40C00000;
        bus.b = 32'h40000000;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("midreset_c", bus.c, 32'd0);
        chk("midreset_busy", {31'd0, bus.busy}, 32'd0);
        chk("midreset_done", {31'd0, bus.done}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 35; i++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) done_seen++;
        end
        chk("midreset_no_done", 32'(done_seen), 32'd0);
        $display("op midreset: c=%h busy=%0d activity=%0d", bus.c, bus.busy, done_seen);
        run_op(32'h40C00000, 32'h40000000, 0, 0, 0, 0, 0, "after_reset");
        chk("after_reset_abs", bus.c, 32'h40400000);

        // Random operands, every other pair steered into the normal range
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 2 == 0) begin
                ra[30:23] = 8'($urandom_range(90, 165));
                rb[30:23] = 8'($urandom_range(90, 165));
            end else if (i % 6 == 1) begin
                ra[30:23] = 8'($urandom_range(240, 254));
                rb[30:23] = 8'($urandom_range(1, 20));
            end else if (i % 6 == 3) begin
                ra[30:23] = 8'($urandom_range(1, 20));
                rb[30:23] = 8'($urandom_range(120, 160));
            end
            run_op(ra, rb, 0, 0, 0, 0, 0, $sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
